pretu_tile_feeder: RTL

PRETU_TILE_FEEDER -- requirements
Module: pretu_tile_feeder

---
 rtl/pretu_pkg.sv | 13 +
 rtl/pretu_line_buf.sv | 25 ++
 rtl/pretu_tile_feeder.sv | 123 ++++++++++++
 3 files changed

// File: rtl/pretu_pkg.sv
// Shared constants and FSM state type for the pretu tile feeder.
package pretu_pkg;

  localparam int unsigned DW_DEF   = 16;
  localparam int unsigned TILE_DIM = 4;
  localparam int unsigned STRIDE   = 2;

  typedef enum logic {
    ST_FILL   = 1'b0,
    ST_STREAM = 1'b1
  } feeder_state_e;

endpackage

// File: rtl/pretu_line_buf.sv
// One image row of pixel storage; the read returns the old word at addr
// in the same cycle it is overwritten, so three of these chained form a
// row-delay shift register indexed by column.
module pretu_line_buf #(
  parameter int unsigned DW    = 16,
  parameter int unsigned IMG_W = 16,
  localparam int unsigned AW   = $clog2(IMG_W)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [IMG_W];

  // Row storage write; contents intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/pretu_tile_feeder.sv
// Raster pixel stream to stride-2 overlapping 4x4 tiles (F(2,3) tiling).
// Optional: define PRETU_FEEDER_STATS_EN to add the tile_count output.
module pretu_tile_feeder
  import pretu_pkg::*;
#(
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned IMG_W = 16,
  parameter int unsigned IMG_H = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic signed [DW-1:0]                in_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [TILE_DIM*TILE_DIM*DW-1:0]     tile_data,
  output logic                                frame_done
`ifdef PRETU_FEEDER_STATS_EN
  ,
  output logic [15:0]                         tile_count
`endif
);

  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);
  localparam int unsigned TW = TILE_DIM * TILE_DIM * DW;

  logic [CW-1:0]  col;
  logic [RW-1:0]  row;
  feeder_state_e  state;
  logic [TW-1:0]  win;
  logic [TW-1:0]  win_next;
  logic [DW-1:0]  lb1_rd, lb2_rd, lb3_rd;
  logic [DW-1:0]  new_col [TILE_DIM];
  logic           accept;
  logic           col_last;
  logic           last_px;
  logic           trigger;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign col_last = (col == CW'(IMG_W - 1));
  assign last_px  = col_last && (row == RW'(IMG_H - 1));
  // Tiles end on odd row/col once a full 4x4 neighbourhood exists;
  // STREAM already implies row >= 3.
  assign trigger  = accept && (state == ST_STREAM) && (row[0] == 1'b1) &&
                    (col[0] == 1'b1) && (col >= CW'(TILE_DIM - 1));

  // Three row delays: lb1 = row r-1, lb2 = r-2, lb3 = r-3 at the current column.
  pretu_line_buf #(.DW(DW), .IMG_W(IMG_W)) u_lb1 (
    .clk(clk), .we(accept), .addr(col), .wdata(in_data), .rdata(lb1_rd));
  pretu_line_buf #(.DW(DW), .IMG_W(IMG_W)) u_lb2 (
    .clk(clk), .we(accept), .addr(col), .wdata(lb1_rd), .rdata(lb2_rd));
  pretu_line_buf #(.DW(DW), .IMG_W(IMG_W)) u_lb3 (
    .clk(clk), .we(accept), .addr(col), .wdata(lb2_rd), .rdata(lb3_rd));

  assign new_col[0] = lb3_rd;
  assign new_col[1] = lb2_rd;
  assign new_col[2] = lb1_rd;
  assign new_col[3] = in_data;

  // Window shifted left one column with the fresh column entering on the right.
  always_comb begin
    win_next = win;
    for (int i = 0; i < int'(TILE_DIM); i++) begin
      for (int j = 0; j < int'(TILE_DIM) - 1; j++) begin
        win_next[(int'(TILE_DIM)*i+j)*int'(DW) +: DW] =
          win[(int'(TILE_DIM)*i+j+1)*int'(DW) +: DW];
      end
      win_next[(int'(TILE_DIM)*i+int'(TILE_DIM)-1)*int'(DW) +: DW] = new_col[i];
    end
  end

  // Window register advances on every accepted pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      win <= '0;
    else if (accept) win <= win_next;
  end

  // Position counters, FILL/STREAM FSM and the single-slot tile output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col        <= '0;
      row        <= '0;
      state      <= ST_FILL;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      tile_data  <= '0;
    end else begin
      frame_done <= accept && last_px;
      if (accept) begin
        if (col_last) begin
          col <= '0;
          row <= last_px ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
        case (state)
          ST_FILL:   if ((row == RW'(TILE_DIM - 1)) && (col == '0)) state <= ST_STREAM;
          ST_STREAM: if (last_px) state <= ST_FILL;
          default:   state <= ST_FILL;
        endcase
      end
      if (trigger) begin
        out_valid <= 1'b1;
        tile_data <= win_next;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef PRETU_FEEDER_STATS_EN
  // Per-frame tile counter, cleared while frame_done is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               tile_count <= '0;
    else if (frame_done)                      tile_count <= '0;
    else if (trigger && tile_count != 16'hFFFF) tile_count <= tile_count + 16'd1;
  end
`endif

endmodule
